popcount_argmax_seq: RTL and testbench
======================================

Name: popcount_argmax_seq

Overview:
Sequential scheduler that time-shares one `count_ones` popcount unit across `InCnt` input words. It returns the index and value of the word with the most set bits.
- A start/done handshake launches a scan over a snapshot of the inputs.
- The block replaces a parallel bank of `count_ones` instances plus combinational max logic where area matters more than latency.

Parameters:
- InCnt, 4, number of words scanned per request (>=2).
- InWdt, 8, bit width of each word (1..65535).
- CntWdt, $clog2(InWdt+1), width of a popcount result (derived; do not override).
- IdxWdt, $clog2(InCnt), width of a word index (derived; do not override).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request a scan; honoured only while ready_o=1.
- data_i  in  InCnt x InWdt  words to scan; sampled only on an accepted start.
- ready_o  out  1  block idle, can accept start_i.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse; result valid and updated this cycle.
- max_idx_o  out  IdxWdt  index of the word with the highest popcount.
- max_cnt_o  out  CntWdt  popcount of that word.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock and reset are clk_i and rst_i.
- Reset values: state=IDLE, ready_o=1, busy_o=0, done_o=0, max_idx_o=0, max_cnt_o=0, internal index/best registers 0.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - ready_o=1.
  - start_i=1 captures all of data_i into a snapshot register array.
  - It clears best_cnt/best_idx to 0 and sets ptr=0, then goes to SCAN.
- SCAN:
  - busy_o=1, ready_o=0.
  - Each cycle the shared `count_ones` evaluates snapshot[ptr].
  - If popcnt > best_cnt (strict), then best_cnt<=popcnt and best_idx<=ptr.
  - If ptr==InCnt-1, go to DONE; otherwise ptr<=ptr+1.
- DONE:
  - done_o=1 for exactly one cycle, ready_o=0, busy_o=0.
  - max_idx_o/max_cnt_o are loaded from best_idx/best_cnt. They are visible in the DONE cycle, so the final compare result is written through on the SCAN->DONE edge.
  - The next state is always IDLE.
- Latency: start accepted at edge T -> SCAN on cycles T+1..T+InCnt -> done_o high in cycle T+InCnt+1. The next start is accepted at the earliest in cycle T+InCnt+2.
- Throughput: one result per InCnt+2 cycles.
- Outputs max_idx_o/max_cnt_o hold the previous result through IDLE and SCAN. They change only on entry to DONE.
- Ties: the lowest index wins, because the compare is strict.
- All-zero words: result idx=0, cnt=0.
- start_i during SCAN or DONE is ignored. It is not queued.
- data_i changes after acceptance have no effect on the running scan.
- Width rules:
  - The `count_ones` 16-bit output is truncated to CntWdt; this is lossless for InWdt<65536.
  - The compare is unsigned at CntWdt.
  - ptr is IdxWdt wide and never wraps, because the terminal compare ends the scan.
- Reset asserted mid-SCAN or in DONE:
  - Immediate return to the reset values.
  - No done_o pulse; the partial result is discarded.
  - After release the block is in IDLE with ready_o=1.

Decomposition:
- Package popcnt_pkg holds:
  - scan_state_e enum {IDLE, SCAN, DONE};
  - a helper function for CntWdt/IdxWdt derivation.
- Sub-module: a single instance of the existing `count_ones` (Width=InWdt), fed by a mux on snapshot[ptr]. No other sub-modules.

Test Plan:
- Reset, then start with data {AA,0F,FF,00} (index 0..3) -> done_o at T+5; max_idx_o=2, max_cnt_o=8; ready_o returns high at T+6.
- Back-to-back start with {55,FF,FE,40} at the first ready cycle after the previous done -> max_idx_o=1, max_cnt_o=8. The previous result (2, 8) is held during the scan.
- Tie and zero cases:
  - {0F,F0,33,00} -> max_idx_o=0, max_cnt_o=4.
  - {00,00,00,00} -> max_idx_o=0, max_cnt_o=0.
- start_i held high through the whole scan, with data_i switched to {FF,FF,FF,FF} after acceptance -> exactly one done_o; the result reflects the snapshot; no second scan until ready_o.
- Assert rst_i asynchronously (mid-cycle) at SCAN ptr=2 -> all outputs zero immediately, no done_o, ready_o=1 after release. A new start then completes normally.
- Parameter sweep InCnt=5, InWdt=13 with word 4 = 1FFF and the others fewer ones -> max_idx_o=4, max_cnt_o=13, done_o at T+6.

Source files
------------

// File: rtl/popcnt_pkg.sv
// Shared types and width helpers for the popcount argmax scheduler.
package popcnt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } scan_state_e;

   // Constant-foldable ceil(log2(v)); used to derive the count and index widths.
   function automatic int unsigned clog2_u(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/count_ones.sv
// Combinational population count with a fixed 16-bit result.
module count_ones #(
   parameter int unsigned Width = 8
) (
   input  logic [Width-1:0] data_i,
   output logic [15:0]      cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int unsigned i = 0; i < Width; i++) begin
         cnt_o = cnt_o + 16'(data_i[i]);
      end
   end

endmodule

// File: rtl/popcount_argmax_seq.sv
// Time-shared popcount scan: one count_ones unit walks a snapshot of InCnt
// words and reports the index and count of the first word with the most ones.
module popcount_argmax_seq
   import popcnt_pkg::*;
#(
   parameter int unsigned InCnt  = 4,
   parameter int unsigned InWdt  = 8,
   parameter int unsigned CntWdt = clog2_u(InWdt + 1),
   parameter int unsigned IdxWdt = clog2_u(InCnt)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [InCnt*InWdt-1:0] data_i,
   output logic                   ready_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [IdxWdt-1:0]      max_idx_o,
   output logic [CntWdt-1:0]      max_cnt_o
);

   scan_state_e       state, state_nxt;
   logic [InWdt-1:0]  snap [InCnt];
   logic [InWdt-1:0]  sel_word;
   logic [15:0]       pc_full;
   logic [CntWdt-1:0] pc, best_cnt, cand_cnt;
   logic [IdxWdt-1:0] ptr, best_idx, cand_idx;
   logic              last;
   logic              unused_pc_hi;

   always_comb begin
      sel_word = '0;
      for (int unsigned i = 0; i < InCnt; i++) begin
         if (ptr == IdxWdt'(i)) sel_word = snap[i];
      end
   end

   count_ones #(.Width(InWdt)) u_count_ones (
      .data_i (sel_word),
      .cnt_o  (pc_full)
   );

   assign pc           = pc_full[CntWdt-1:0];
   assign unused_pc_hi = ^pc_full;
   assign last         = (ptr == IdxWdt'(InCnt - 1));

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      cand_cnt = best_cnt;
      cand_idx = best_idx;
      if (pc > best_cnt) begin
         cand_cnt = pc;
         cand_idx = ptr;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_o   = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (start_i) state_nxt = SCAN;
         end
         SCAN: begin
            busy_o = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < InCnt; i++) snap[i] <= '0;
         ptr       <= '0;
         best_cnt  <= '0;
         best_idx  <= '0;
         max_idx_o <= '0;
         max_cnt_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  for (int unsigned i = 0; i < InCnt; i++) begin
                     snap[i] <= data_i[i*InWdt +: InWdt];
                  end
                  ptr      <= '0;
                  best_cnt <= '0;
                  best_idx <= '0;
               end
            end
            SCAN: begin
               best_cnt <= cand_cnt;
               best_idx <= cand_idx;
               // Final compare is written straight to the outputs so the
               // result is visible in the DONE cycle.
               if (last) begin
                  max_idx_o <= cand_idx;
                  max_cnt_o <= cand_cnt;
               end else begin
                  ptr <= ptr + IdxWdt'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_popcount_argmax_seq.sv
// Directed bench for popcount_argmax_seq (4x8 instance plus a 5x13 instance).
module tb_popcount_argmax_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start_a = 1'b0;
   logic [31:0] data_a  = '0;
   logic        ready_a, busy_a, done_a;
   logic [1:0]  idx_a;
   logic [3:0]  cnt_a;

   logic        start_b = 1'b0;
   logic [64:0] data_b  = '0;
   logic        ready_b, busy_b, done_b;
   logic [2:0]  idx_b;
   logic [3:0]  cnt_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   popcount_argmax_seq #(.InCnt(4), .InWdt(8)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start_a), .data_i(data_a),
      .ready_o(ready_a), .busy_o(busy_a), .done_o(done_a),
      .max_idx_o(idx_a), .max_cnt_o(cnt_a)
   );

   popcount_argmax_seq #(.InCnt(5), .InWdt(13)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .data_i(data_b),
      .ready_o(ready_b), .busy_o(busy_b), .done_o(done_b),
      .max_idx_o(idx_b), .max_cnt_o(cnt_b)
   );

   typedef struct {
      logic [31:0] data;
      bit          hold;
      int          exp_idx;
      int          exp_cnt;
   } vec_t;

   vec_t vecs[5];
   int   prev_idx;
   int   prev_cnt;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Launch one scan on dut_a; data_a is disturbed after acceptance.
   task automatic scan_a(input logic [31:0] d, input bit hold, input int ei,
                         input int ec, input int pi, input int pc, input string tag);
      int lat;
      @(negedge clk);
      start_a = 1'b1;
      data_a  = d;
      @(posedge clk); #1;
      chk({tag, "_busy"}, busy_a, 1);
      chk({tag, "_held_idx"}, idx_a, pi);
      chk({tag, "_held_cnt"}, cnt_a, pc);
      data_a = hold ? 32'hFFFF_FFFF : ~d;
      if (!hold) start_a = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done_a) begin
            lat = k;
            break;
         end
         chk({tag, "_busy_scan"}, busy_a, 1);
      end
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_idx"}, idx_a, ei);
      chk({tag, "_cnt"}, cnt_a, ec);
      chk({tag, "_done_ready"}, ready_a, 0);
      @(posedge clk); #1;
      chk({tag, "_done_once"}, done_a, 0);
      chk({tag, "_ready_back"}, ready_a, 1);
      start_a = 1'b0;
   endtask

   initial begin
      int lat;
      vecs[0] = '{32'h00FF_0FAA, 1'b0, 2, 8};
      vecs[1] = '{32'h40FE_FF55, 1'b0, 1, 8};
      vecs[2] = '{32'h0033_F00F, 1'b0, 0, 4};
      vecs[3] = '{32'h0000_0000, 1'b0, 0, 0};
      vecs[4] = '{32'h0007_0301, 1'b1, 2, 3};

      #12;
      chk("rst_ready", ready_a, 1);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_idx", idx_a, 0);
      chk("rst_cnt", cnt_a, 0);
      @(negedge clk);
      rst = 1'b0;

      prev_idx = 0;
      prev_cnt = 0;
      foreach (vecs[i]) begin
         scan_a(vecs[i].data, vecs[i].hold, vecs[i].exp_idx, vecs[i].exp_cnt,
                prev_idx, prev_cnt, $sformatf("v%0d", i));
         prev_idx = vecs[i].exp_idx;
         prev_cnt = vecs[i].exp_cnt;
      end

      // Asynchronous reset while ptr==2.
      @(negedge clk);
      start_a = 1'b1;
      data_a  = 32'hF0E0_C080;
      @(posedge clk);
      start_a = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_ready", ready_a, 1);
      chk("arst_busy", busy_a, 0);
      chk("arst_done", done_a, 0);
      chk("arst_idx", idx_a, 0);
      chk("arst_cnt", cnt_a, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("arst_no_done", done_a, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst_release_ready", ready_a, 1);
      scan_a(32'h1100_0010, 1'b0, 3, 2, 0, 0, "post_rst");

      // Wider instance: word 4 = 1FFF, words 2 and 3 carry 12 ones each.
      @(negedge clk);
      start_b = 1'b1;
      data_b  = {13'h1FFF, 13'h1FFE, 13'h0FFF, 13'h0003, 13'h0001};
      @(posedge clk); #1;
      start_b = 1'b0;
      data_b  = '0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done_b) begin
            lat = k;
            break;
         end
      end
      chk("b_latency", lat, 5);
      chk("b_idx", idx_b, 4);
      chk("b_cnt", cnt_b, 13);
      @(posedge clk); #1;
      chk("b_ready_back", ready_b, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
